// File: rtl/dev_timer.sv
// Memory-mapped down-counting timer with one-shot/auto-reload modes and a pending interrupt.
// Optional prescaler enabled by defining DEV_TIMER_PRESCALER_EN.
module dev_timer #(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] dev_out,
  input  logic [31:0] dev_in,
  input  logic [7:0]  dev_addr,
  input  logic        we,
  output logic        irq
);

  typedef enum logic [1:0] {StIdle, StLoad, StCounting} state_e;

  state_e      r_state, w_state_nxt;
  logic        r_en, w_en_nxt;
  logic        r_reload, w_reload_nxt;
  logic        r_ie, w_ie_nxt;
  logic [31:0] r_preset, w_preset_nxt;
  logic [31:0] r_count, w_count_nxt;
  logic        r_pending, w_pending_nxt;

  logic        w_wr_ctrl, w_wr_preset, w_wr_count, w_wr_status, w_wr_prescale;
  logic        w_tick, w_expire, w_count_is_last;
  logic [31:0] w_reload_val;

  assign w_wr_ctrl     = we && (dev_addr == 8'h00);
  assign w_wr_preset   = we && (dev_addr == 8'h04);
  assign w_wr_count    = we && (dev_addr == 8'h08);
  assign w_wr_status   = we && (dev_addr == 8'h0C);
  assign w_wr_prescale = we && (dev_addr == 8'h10);

  // COUNT == 0 while counting behaves like COUNT == 1; PRESET == 0 loads as 1.
  assign w_count_is_last = (r_count <= 32'd1);
  assign w_reload_val    = (r_preset == 32'd0) ? 32'd1 : r_preset;

`ifdef DEV_TIMER_PRESCALER_EN
  logic [PRESCALE_W-1:0] r_prescale, w_prescale_nxt;
  logic [PRESCALE_W-1:0] r_pre_cnt, w_pre_cnt_nxt;

  assign w_tick = (r_state == StCounting) && (r_pre_cnt == r_prescale);
`else
  logic w_unused_prescale_w;

  assign w_tick = (r_state == StCounting);
  // Keeps the width parameter referenced in builds without a prescaler.
  assign w_unused_prescale_w = w_wr_prescale & (^dev_in[PRESCALE_W-1:0]);
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_en_nxt      = r_en;
    w_reload_nxt  = r_reload;
    w_ie_nxt      = r_ie;
    w_preset_nxt  = r_preset;
    w_count_nxt   = r_count;
    w_pending_nxt = r_pending;
    w_expire      = 1'b0;
`ifdef DEV_TIMER_PRESCALER_EN
    w_prescale_nxt = r_prescale;
    w_pre_cnt_nxt  = r_pre_cnt;
`endif

    unique case (r_state)
      StIdle: w_state_nxt = StIdle;
      StLoad: begin
        w_count_nxt = w_reload_val;
`ifdef DEV_TIMER_PRESCALER_EN
        w_pre_cnt_nxt = '0;
`endif
        w_state_nxt = StCounting;
      end
      StCounting: begin
`ifdef DEV_TIMER_PRESCALER_EN
        w_pre_cnt_nxt = w_tick ? '0 : r_pre_cnt + PRESCALE_W'(1);
`endif
        if (w_tick) begin
          if (!w_count_is_last) begin
            w_count_nxt = r_count - 32'd1;
          end else begin
            w_expire = 1'b1;
            if (r_reload) begin
              w_count_nxt = w_reload_val;
            end else begin
              w_count_nxt = 32'd0;
              w_en_nxt    = 1'b0;
              w_state_nxt = StIdle;
            end
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase

    // Software writes take priority over the hardware updates above.
    if (w_wr_ctrl) begin
      w_en_nxt     = dev_in[0];
      w_reload_nxt = dev_in[1];
      w_ie_nxt     = dev_in[2];
      w_state_nxt  = dev_in[0] ? StLoad : StIdle;
    end
    if (w_wr_preset) w_preset_nxt = dev_in;
    if (w_wr_count)  w_count_nxt  = dev_in;
`ifdef DEV_TIMER_PRESCALER_EN
    if (w_wr_prescale) w_prescale_nxt = dev_in[PRESCALE_W-1:0];
`endif

    // Expiry beats a simultaneous clear.
    if (w_wr_status && dev_in[0]) w_pending_nxt = 1'b0;
    if (w_expire)                 w_pending_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_en      <= 1'b0;
      r_reload  <= 1'b0;
      r_ie      <= 1'b0;
      r_preset  <= 32'd0;
      r_count   <= 32'd0;
      r_pending <= 1'b0;
`ifdef DEV_TIMER_PRESCALER_EN
      r_prescale <= '0;
      r_pre_cnt  <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_en      <= w_en_nxt;
      r_reload  <= w_reload_nxt;
      r_ie      <= w_ie_nxt;
      r_preset  <= w_preset_nxt;
      r_count   <= w_count_nxt;
      r_pending <= w_pending_nxt;
`ifdef DEV_TIMER_PRESCALER_EN
      r_prescale <= w_prescale_nxt;
      r_pre_cnt  <= w_pre_cnt_nxt;
`endif
    end
  end

  always_comb begin
    dev_out = 32'hdead_beef;
    unique case (dev_addr)
      8'h00: dev_out = {29'd0, r_ie, r_reload, r_en};
      8'h04: dev_out = r_preset;
      8'h08: dev_out = r_count;
      8'h0C: dev_out = {31'd0, r_pending};
`ifdef DEV_TIMER_PRESCALER_EN
      8'h10: dev_out = 32'(r_prescale);
`endif
      default: dev_out = 32'hdead_beef;
    endcase
  end

  assign irq = r_pending & r_ie;

endmodule

// File: tb/tb_dev_timer.sv
// Self-checking bench for dev_timer; expected timing comes from closed-form expiry formulas
// over randomized PRESET/PRESCALE values.
module tb_dev_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dev_out;
  logic [31:0] dev_in;
  logic [7:0]  dev_addr;
  logic        we;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

`ifdef DEV_TIMER_PRESCALER_EN
  localparam bit HasPre = 1'b1;
  localparam logic [31:0] PrescaleRst = 32'h0;
`else
  localparam bit HasPre = 1'b0;
  localparam logic [31:0] PrescaleRst = 32'hdead_beef;
`endif

  dev_timer #(.PRESCALE_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .dev_out  (dev_out),
    .dev_in   (dev_in),
    .dev_addr (dev_addr),
    .we       (we),
    .irq      (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Effective prescale: builds without a prescaler tick every cycle.
  function automatic int eff_s(input int s);
    return HasPre ? s : 0;
  endfunction

  // Called in the low clock phase; returns just after the write edge.
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    we = 1'b1; dev_addr = a; dev_in = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    dev_addr = a;
    #1;
    d = dev_out;
  endtask

  task automatic do_reset();
    rst = 1'b1; we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [31:0] exp_v [6];
    exp_v = '{32'h0, 32'h0, 32'h0, 32'h0, PrescaleRst, 32'hdead_beef};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i == 3) @(negedge clk);
      rd(8'(i * 4), d);
      n_checks++;
      if (d !== exp_v[i]) begin
        n_fail++;
        $display("FAIL reset_read off=%0h: got %h expected %h", i * 4, d, exp_v[i]);
      end
    end
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_irq: got %b expected 0", irq);
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    int p, s, se, pe, t, exp_c, exp_p;
    for (int it = 0; it < 5; it++) begin
      p = (it == 0) ? 3 : (it == 1) ? 0 : $urandom_range(0, 5);
      s = (it < 2) ? 0 : $urandom_range(0, 3);
      se = eff_s(s);
      pe = (p == 0) ? 1 : p;
      t = pe * (se + 1) + 1;
      do_reset();
      wr(8'h10, 32'(s));
      wr(8'h04, 32'(p));
      wr(8'h00, 32'h5);
      for (int k = 1; k <= t + 1; k++) begin
        @(negedge clk);
        exp_c = (k >= t) ? 0 : pe - (k - 1) / (se + 1);
        exp_p = (k >= t) ? 1 : 0;
        rd(8'h08, d);
        n_checks++;
        if (d !== 32'(exp_c)) begin
          n_fail++;
          $display("FAIL oneshot_count p=%0d s=%0d k=%0d: got %0d expected %0d", p, s, k, d, exp_c);
        end
        rd(8'h0C, d);
        n_checks++;
        if (d !== 32'(exp_p) || irq !== exp_p[0]) begin
          n_fail++;
          $display("FAIL oneshot_pending p=%0d s=%0d k=%0d: got %0d/irq %b expected %0d",
                   p, s, k, d, irq, exp_p);
        end
      end
      rd(8'h00, d);
      n_checks++;
      if (d !== 32'h4) begin
        n_fail++;
        $display("FAIL oneshot_ctrl: got %h expected 00000004", d);
      end
    end
  endtask

  task automatic test_auto_reload();
    logic [31:0] d;
    int se, r, e;
    se = eff_s(4);
    r = 2 * (se + 1);
    do_reset();
    wr(8'h10, 32'd4);
    wr(8'h04, 32'd2);
    wr(8'h00, 32'h3);
    e = cyc + r + 1;
    for (int j = 0; j < 3; j++) begin
      while (cyc < e - 1) @(negedge clk);
      rd(8'h0C, d);
      n_checks++;
      if (d !== 32'd0) begin
        n_fail++;
        $display("FAIL reload_early j=%0d: got %0d expected 0", j, d);
      end
      @(negedge clk);
      rd(8'h0C, d);
      n_checks++;
      if (d !== 32'd1 || irq !== 1'b0) begin
        n_fail++;
        $display("FAIL reload_pending j=%0d: got %0d/irq %b expected 1/irq 0", j, d, irq);
      end
      rd(8'h08, d);
      n_checks++;
      if (d !== 32'd2) begin
        n_fail++;
        $display("FAIL reload_count j=%0d: got %0d expected 2", j, d);
      end
      wr(8'h0C, 32'h1);
      e = e + r;
    end
  endtask

  task automatic test_clear_collision();
    logic [31:0] d;
    int p, s, r, e;
    p = $urandom_range(2, 4);
    s = $urandom_range(0, 3);
    r = p * (eff_s(s) + 1);
    do_reset();
    wr(8'h10, 32'(s));
    wr(8'h04, 32'(p));
    wr(8'h00, 32'h7);
    e = cyc + r + 1;
    while (cyc < e - 1) @(negedge clk);
    wr(8'h0C, 32'h1);
    rd(8'h0C, d);
    n_checks++;
    if (d !== 32'd1 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL collide_set_wins: got %0d/irq %b expected 1/irq 1", d, irq);
    end
    wr(8'h0C, 32'h1);
    rd(8'h0C, d);
    n_checks++;
    if (d !== 32'd0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL collide_clear: got %0d/irq %b expected 0/irq 0", d, irq);
    end
  endtask

  task automatic test_disable();
    logic [31:0] d;
    int w0, kd, exp_c;
    do_reset();
    wr(8'h10, 32'd0);
    wr(8'h04, 32'd100);
    wr(8'h00, 32'h1);
    w0 = cyc;
    repeat ($urandom_range(3, 20)) @(negedge clk);
    wr(8'h00, 32'h0);
    kd = cyc - w0;
    exp_c = 100 - (kd - 1);
    repeat (5) @(negedge clk);
    rd(8'h08, d);
    n_checks++;
    if (d !== 32'(exp_c)) begin
      n_fail++;
      $display("FAIL disable_freeze: got %0d expected %0d", d, exp_c);
    end
    rd(8'h00, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL disable_ctrl: got %h expected 0", d);
    end
  endtask

  task automatic test_count_write();
    logic [31:0] d;
    do_reset();
    wr(8'h10, 32'd0);
    wr(8'h04, 32'd50);
    wr(8'h00, 32'h5);
    repeat (4) @(negedge clk);
    wr(8'h08, 32'd0);
    rd(8'h08, d);
    n_checks++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL cntwr_value: got %0d expected 0", d);
    end
    rd(8'h0C, d);
    n_checks++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL cntwr_no_early: got %0d expected 0", d);
    end
    @(negedge clk);
    rd(8'h0C, d);
    n_checks++;
    if (d !== 32'd1 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL cntwr_expire: got %0d/irq %b expected 1/irq 1", d, irq);
    end
    rd(8'h00, d);
    n_checks++;
    if (d !== 32'h4) begin
      n_fail++;
      $display("FAIL cntwr_ctrl: got %h expected 00000004", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [31:0] exp_v [5];
    exp_v = '{32'h0, 32'h0, 32'h0, 32'h0, PrescaleRst};
    do_reset();
    wr(8'h10, 32'd1);
    wr(8'h04, 32'd1);
    wr(8'h00, 32'h7);
    repeat (eff_s(1) + 2) @(negedge clk);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre_irq: got %b expected 1", irq);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_irq: got %b expected 0", irq);
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 3) @(negedge clk);
      rd(8'(i * 4), d);
      n_checks++;
      if (d !== exp_v[i]) begin
        n_fail++;
        $display("FAIL rstmid_read off=%0h: got %h expected %h", i * 4, d, exp_v[i]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_prescale_reg();
    logic [31:0] d;
    int w0;
    do_reset();
    wr(8'h10, 32'hffff_0007);
    wr(8'h04, 32'd5);
    wr(8'h00, 32'h1);
    w0 = cyc;
    rd(8'h10, d);
    n_checks++;
    if (d !== (HasPre ? 32'h7 : 32'hdead_beef)) begin
      n_fail++;
      $display("FAIL prescale_read: got %h expected %h", d, HasPre ? 32'h7 : 32'hdead_beef);
    end
    while (cyc < w0 + 5 * (eff_s(7) + 1)) @(negedge clk);
    rd(8'h0C, d);
    n_checks++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL prescale_early: got %0d expected 0", d);
    end
    @(negedge clk);
    rd(8'h0C, d);
    n_checks++;
    if (d !== 32'd1) begin
      n_fail++;
      $display("FAIL prescale_expire: got %0d expected 1", d);
    end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; dev_addr = 8'h00; dev_in = 32'h0;
    @(negedge clk);
    test_reset();
    test_oneshot();
    test_auto_reload();
    test_clear_collision();
    test_disable();
    test_count_write();
    test_reset_mid();
    test_prescale_reg();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
